sgbm_pixel_sched: RTL
=====================

SGBM_PIXEL_SCHED -- requirements
Module: sgbm_pixel_sched

Interface
REQ-001 SHALL have parameter IMAGE_ROW, default 200, frame height in pixels.
REQ-002 SHALL have parameter IMAGE_COL, default 400, frame width in pixels.
REQ-003 SHALL have parameter ADDR_W, default 17, pixel-memory address width (IMAGE_ROW*IMAGE_COL <= 2^ADDR_W).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 start  in  1  frame start request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous frame cancel.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when a frame completes normally.
REQ-010 mem_rd_en  out  1  read strobe to the left and right image memories.
REQ-011 mem_addr  out  ADDR_W  shared read address, row*IMAGE_COL+col.
REQ-012 mem_rdata_left  in  8  left grey pixel, valid exactly 1 cycle after mem_rd_en.
REQ-013 mem_rdata_right  in  8  right grey pixel, same timing.
REQ-014 grey_left / grey_right  out  8 each  output pixel pair.
REQ-015 grey_row / grey_col  out  10 each  coordinates of the output pixel pair.
REQ-016 valid  out  1  output pair valid; ready  in  1  downstream accepts.
REQ-017 sof / eof  out  1 each  qualify first (0,0) / last (IMAGE_ROW-1, IMAGE_COL-1) pixel while valid.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after the read of the last address issues; DRAIN->DONE on handshake of the eof pixel; DONE->IDLE unconditionally after 1 cycle.
REQ-019 Raster order SHALL be col 0..IMAGE_COL-1 inner, row 0..IMAGE_ROW-1 outer; col wraps to 0 and row increments on the same read.
REQ-020 mem_addr SHALL be kept by an incrementing counter (no multiplier), reset to 0 at each frame start.
REQ-021 Read data plus its row/col tag SHALL enter a 2-entry output FIFO the cycle after mem_rd_en.
REQ-022 A read SHALL issue only if occupancy + in_flight - pop < 2, where pop = valid && ready; no entry is ever dropped or overwritten.
REQ-023 Output handshake: a pair transfers when valid && ready; while valid && !ready, all output data/tag/sof/eof SHALL hold stable.
REQ-024 Latency: start sampled at edge ending cycle 0 -> mem_rd_en cycle 1 with addr 0 -> valid cycle 3.
REQ-025 With ready held high, throughput SHALL be 1 pixel pair per cycle with no bubbles.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 abort in any non-IDLE state SHALL, at the next edge, flush FIFO and in-flight read, drop valid, force IDLE, with no done pulse; abort has priority over start in the same cycle.
REQ-028 done SHALL assert the cycle after the eof handshake, for exactly one cycle.
REQ-029 mem_rd_en SHALL never assert in IDLE, DRAIN or DONE.

Reset
REQ-030 While rst=0: state=IDLE, counters/FIFO cleared; busy, done, mem_rd_en, valid, sof, eof = 0; mem_addr, grey_*, grey_row, grey_col = 0.
REQ-031 Reset assertion mid-frame SHALL abandon the frame; after release the block waits in IDLE for a new start.

Structure
REQ-032 IMAGE_ROW/IMAGE_COL defaults, ADDR_W, pixel width 8, coordinate width 10, and FSM state encodings SHALL live in shared package sgbm_pkg.
REQ-033 The 2-entry output FIFO SHALL be sub-module sgbm_skid_fifo (payload 8+8+10+10+1+1 bits, valid/ready both sides).

Verification
REQ-034 Reset: rst=0 for 10 cycles with random start/ready -> all outputs 0, busy=0.
REQ-035 IMAGE_ROW=3, IMAGE_COL=4, ready=1, start at cycle 0 -> mem_rd_en cycles 1-12 with addr 0-11; valid cycles 3-14; sof cycle 3; eof cycle 14 at (2,3); done cycle 15 only; busy=0 from cycle 16.
REQ-036 Same config, ready=0 cycles 3-12 -> exactly 2 reads beyond those already accepted, then mem_rd_en=0; (0,0) held stable; after ready=1 all 12 pairs arrive in order, no duplicates.
REQ-037 abort at cycle 6 of a frame -> valid=0, busy=0 from cycle 7, no done; new start at cycle 10 restarts at addr 0.
REQ-038 start pulses during RUN and start+abort together in IDLE -> no restart, state remains unchanged / IDLE.
REQ-039 rst=0 at cycle 8 mid-frame -> outputs 0 immediately (asynchronous); after release, no activity until start.

Source files
------------

// File: rtl/sgbm_pkg.sv
// Shared constants, types and helpers for the SGBM pixel-pair scheduler.
package sgbm_pkg;

   localparam int IMAGE_ROW_DEF = 200;
   localparam int IMAGE_COL_DEF = 400;
   localparam int ADDR_W_DEF    = 17;
   localparam int PIX_W         = 8;
   localparam int COORD_W       = 10;

   localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   // One output pair with its raster tag; left is the most significant field.
   typedef struct packed {
      logic [PIX_W-1:0]   left;
      logic [PIX_W-1:0]   right;
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
      logic               sof;
      logic               eof;
   } pix_pair_t;

   localparam int PAYLOAD_W = $bits(pix_pair_t);

   // A new read may issue only while the FIFO can still absorb it once the
   // data returns: occupancy + read in flight - pop this cycle must stay below 2.
   function automatic logic issue_ok(input logic [1:0] occ,
                                     input logic       in_flight,
                                     input logic       pop);
      logic [2:0] load_v;
      logic [2:0] limit_v;
      load_v  = {1'b0, occ} + {2'b00, in_flight};
      limit_v = 3'd2 + {2'b00, pop};
      return (load_v < limit_v);
   endfunction

endpackage

// File: rtl/sgbm_skid_fifo.sv
// Two-entry output FIFO; entry 0 is always the head, so the outputs come
// straight from registers and stay stable while the consumer stalls.
module sgbm_skid_fifo
   import sgbm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           count
);

   logic [PAYLOAD_W-1:0] ent0_r;
   logic [PAYLOAD_W-1:0] ent1_r;
   logic [1:0]           cnt_r;
   logic [PAYLOAD_W-1:0] ent0_nxt_s;
   logic [PAYLOAD_W-1:0] ent1_nxt_s;
   logic [1:0]           cnt_nxt_s;
   logic                 push_s;
   logic                 pop_s;

   assign out_valid = (cnt_r != 2'd0);
   assign out_data  = ent0_r;
   assign count     = cnt_r;

   // Handshake decode on both sides.
   always_comb begin
      pop_s    = (cnt_r != 2'd0) && out_ready;
      in_ready = (cnt_r != 2'd2) || pop_s;
      push_s   = in_valid && in_ready;
   end

   // Next entry contents: pops shift entry 1 forward, pushes fill the first free slot.
   always_comb begin
      ent0_nxt_s = ent0_r;
      ent1_nxt_s = ent1_r;
      cnt_nxt_s  = cnt_r;
      case ({push_s, pop_s})
         2'b10: begin
            if (cnt_r == 2'd0) begin
               ent0_nxt_s = in_data;
            end else begin
               ent1_nxt_s = in_data;
            end
            cnt_nxt_s = cnt_r + 2'd1;
         end
         2'b01: begin
            ent0_nxt_s = ent1_r;
            cnt_nxt_s  = cnt_r - 2'd1;
         end
         2'b11: begin
            if (cnt_r == 2'd1) begin
               ent0_nxt_s = in_data;
            end else begin
               ent0_nxt_s = ent1_r;
               ent1_nxt_s = in_data;
            end
         end
         default: begin
            cnt_nxt_s = cnt_r;
         end
      endcase
   end

   // Storage registers; flush empties the FIFO and clears the head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0_r <= '0;
         ent1_r <= '0;
         cnt_r  <= 2'd0;
      end else if (flush) begin
         ent0_r <= '0;
         ent1_r <= '0;
         cnt_r  <= 2'd0;
      end else begin
         ent0_r <= ent0_nxt_s;
         ent1_r <= ent1_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

endmodule

// File: rtl/sgbm_pixel_sched.sv
// Raster-order read scheduler for the left/right grey images: issues shared
// reads, tags returning data with row/col and streams pairs out with valid/ready.
module sgbm_pixel_sched
   import sgbm_pkg::*;
#(
   parameter int IMAGE_ROW = IMAGE_ROW_DEF,
   parameter int IMAGE_COL = IMAGE_COL_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIX_W-1:0]   mem_rdata_left,
   input  logic [PIX_W-1:0]   mem_rdata_right,
   output logic [PIX_W-1:0]   grey_left,
   output logic [PIX_W-1:0]   grey_right,
   output logic [COORD_W-1:0] grey_row,
   output logic [COORD_W-1:0] grey_col,
   output logic               valid,
   input  logic               ready,
   output logic               sof,
   output logic               eof
);

   localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMAGE_ROW - 1);
   localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMAGE_COL - 1);

   sched_state_t         state_r;
   sched_state_t         state_nxt_s;
   logic [ADDR_W-1:0]    addr_r;
   logic [COORD_W-1:0]   row_r;
   logic [COORD_W-1:0]   col_r;
   logic                 inflight_r;
   logic [COORD_W-1:0]   tag_row_r;
   logic [COORD_W-1:0]   tag_col_r;
   logic                 tag_sof_r;
   logic                 tag_eof_r;

   logic                 rd_en_s;
   logic                 pop_s;
   logic                 flush_s;
   logic                 frame_go_s;
   logic                 last_s;
   logic                 fifo_in_valid_s;
   logic                 fifo_in_ready_s;
   logic                 fifo_out_valid_s;
   logic [1:0]           fifo_count_s;
   logic [PAYLOAD_W-1:0] fifo_out_data_s;
   pix_pair_t            push_pair_s;
   pix_pair_t            head_s;

   assign head_s     = pix_pair_t'(fifo_out_data_s);
   assign busy       = (state_r != ST_IDLE);
   assign done       = (state_r == ST_DONE);
   assign mem_rd_en  = rd_en_s;
   assign mem_addr   = addr_r;
   assign valid      = fifo_out_valid_s;
   assign grey_left  = head_s.left;
   assign grey_right = head_s.right;
   assign grey_row   = head_s.row;
   assign grey_col   = head_s.col;
   assign sof        = head_s.sof;
   assign eof        = head_s.eof;

   // Control decode: output pop, frame cancel/start, read issue throttle.
   always_comb begin
      pop_s      = fifo_out_valid_s && ready;
      flush_s    = abort && (state_r != ST_IDLE);
      frame_go_s = (state_r == ST_IDLE) && start && !abort;
      last_s     = (row_r == ROW_LAST) && (col_r == COL_LAST);
      if ((state_r == ST_RUN) && !abort && issue_ok(fifo_count_s, inflight_r, pop_s)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Frame sequencing: abort wins over everything, DONE lasts a single cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (rd_en_s && last_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (pop_s && head_s.eof) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Raster counters: address counts linearly, col wraps into row on the same read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_r <= '0;
         row_r  <= '0;
         col_r  <= '0;
      end else if (flush_s || frame_go_s) begin
         addr_r <= '0;
         row_r  <= '0;
         col_r  <= '0;
      end else if (rd_en_s) begin
         addr_r <= addr_r + ADDR_W'(1'b1);
         if (col_r == COL_LAST) begin
            col_r <= '0;
            row_r <= row_r + COORD_ONE;
         end else begin
            col_r <= col_r + COORD_ONE;
         end
      end else begin
         addr_r <= addr_r;
      end
   end

   // Tag of the read in flight, aligned with the data returning next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_r <= 1'b0;
         tag_row_r  <= '0;
         tag_col_r  <= '0;
         tag_sof_r  <= 1'b0;
         tag_eof_r  <= 1'b0;
      end else if (flush_s) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= rd_en_s;
         if (rd_en_s) begin
            tag_row_r <= row_r;
            tag_col_r <= col_r;
            tag_sof_r <= (row_r == '0) && (col_r == '0);
            tag_eof_r <= last_s;
         end else begin
            tag_row_r <= tag_row_r;
         end
      end
   end

   // Returning memory data joined with its tag forms the FIFO payload.
   always_comb begin
      push_pair_s.left  = mem_rdata_left;
      push_pair_s.right = mem_rdata_right;
      push_pair_s.row   = tag_row_r;
      push_pair_s.col   = tag_col_r;
      push_pair_s.sof   = tag_sof_r;
      push_pair_s.eof   = tag_eof_r;
      fifo_in_valid_s   = inflight_r && fifo_in_ready_s;
   end

   sgbm_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_s),
      .in_valid  (fifo_in_valid_s),
      .in_ready  (fifo_in_ready_s),
      .in_data   (push_pair_s),
      .out_valid (fifo_out_valid_s),
      .out_ready (ready),
      .out_data  (fifo_out_data_s),
      .count     (fifo_count_s)
   );

endmodule
